pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives the enable and bubble/flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three cases:
  - load-use hazards;
  - taken-branch and ret redirects;
  - multi-cycle data-memory waits.
- Latches the halt condition.

Parameters:
- MEM_TIMEOUT, 15: number of consecutive MEM_WAIT cycles after which mem_timeout is raised.
- REG_ADDR_W, 4: register-index width; 16 registers, R0 hardwired to zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_reg_rd  in  REG_ADDR_W  destination of the instruction in EX.
- ifid_reg_rs  in  REG_ADDR_W  source 1 of the instruction in ID.
- ifid_reg_rt  in  REG_ADDR_W  source 2 of the instruction in ID.
- ifid_uses_rs  in  1  ID instruction reads rs.
- ifid_uses_rt  in  1  ID instruction reads rt.
- exmem_mem_access  in  1  MEM-stage instruction is a load or store (MemRead|MemWrite).
- mem_ready  in  1  data memory completes the access this cycle.
- branch_taken  in  1  branch resolved taken in EX.
- ret_wb  in  1  ret reaching WB (PC redirect).
- hlt_wb  in  1  hlt reaching WB.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads a NOP (all control bits 0).
- exmem_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  MEM/WB loads a NOP.
- halted  out  1  pipeline halted.
- mem_timeout  out  1  sticky memory-timeout flag.
- state  out  2  current FSM state, for debug.

Behaviour:
- State is registered. All control outputs are combinational decode of state plus the current-cycle inputs.
- Encoding: RUN=00, LU_STALL=01, MEM_WAIT=10, HALT=11.
- While rst=1:
  - state goes to RUN; wait counter and mem_timeout clear to 0; halted=0.
  - Outputs: all enables=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1.
  - Reset mid-stall or mid-wait abandons the stall or wait; state is RUN on the first cycle after rst falls.
- Default output decode: all enables=1, all flush/bubble=0.
- Load-use hazard definition: idex_mem_read && idex_reg_rd!=0 && ((ifid_uses_rs && ifid_reg_rs==idex_reg_rd) || (ifid_uses_rt && ifid_reg_rt==idex_reg_rd)).
- Priority within RUN and LU_STALL: hlt_wb > memory wait > redirect > load-use.
- HALT:
  - Entered from any state on hlt_wb=1.
  - Outputs in HALT: all enables=0, memwb_bubble=1, halted=1.
  - Exited only by rst. The cycle hlt_wb is seen already uses HALT outputs.
- Memory wait (exmem_mem_access=1 && mem_ready=0):
  - Freeze pc_en, ifid_en, idex_en and exmem_en (all =0); memwb_bubble=1.
  - Next state is MEM_WAIT.
- MEM_WAIT:
  - Freeze as above while mem_ready=0; the wait counter increments and saturates at MEM_TIMEOUT.
  - When the counter equals MEM_TIMEOUT, mem_timeout is set and stays set until rst; the FSM keeps waiting.
  - Release cycle (mem_ready=1): enables=1, memwb_bubble=0, counter cleared, next state RUN.
  - A redirect present on the release cycle is applied in the same cycle.
  - hlt_wb and redirects arriving during the freeze are held upstream and are serviced on release.
  - A zero-wait access (mem_ready=1 in the same cycle) never leaves RUN.
- Redirect (branch_taken || ret_wb):
  - ifid_flush=1 and idex_bubble=1; all enables stay 1.
  - State unchanged; lasts exactly one cycle per assertion.
  - A redirect overrides a simultaneous load-use hazard: the hazard instruction is squashed, so no stall is taken.
- Load-use hazard in RUN:
  - pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1.
  - Next state LU_STALL.
- LU_STALL:
  - Default outputs; next state RUN.
  - A second hazard is not re-evaluated here, because the instruction in EX is now the bubble.
  - Net effect: exactly one stall cycle per load-use.
- Writing to R0 (idex_reg_rd=0) never stalls.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs stall_cycles[15:0] and flush_count[15:0]. Both are saturating counters that reset to 0.
  - stall_cycles increments on every cycle with pc_en=0 while not in HALT.
  - flush_count increments on every redirect cycle.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use stall: load R3 in EX, ID instruction reads rs=3 with uses_rs=1.
  - Cycle 1: pc_en=0, ifid_en=0, idex_bubble=1, next state LU_STALL.
  - Cycle 2: default outputs, state returns to RUN.
- R0 exemption: load with rd=0 and ID rs=0 -> no stall, state stays RUN.
- Memory wait: mem_ready low for 3 cycles with exmem_mem_access=1.
  - 3 frozen cycles with memwb_bubble=1.
  - Release on the 4th cycle; state sequence RUN, MEM_WAIT, MEM_WAIT, MEM_WAIT, RUN.
- Timeout: mem_ready held low for 20 cycles with MEM_TIMEOUT=15.
  - mem_timeout rises when the counter reaches 15 and stays 1 after release, until rst.
- Redirect vs load-use: branch_taken=1 together with a load-use hazard.
  - ifid_flush=1, idex_bubble=1, pc_en=1, state stays RUN.
- Halt and reset: hlt_wb=1 during a load-use stall -> HALT with halted=1 and all enables 0.
  - rst for 1 cycle -> outputs at reset values, then RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard-controller signal bundle; perf counters appear when HAZARD_PERF_EN is defined
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  idex_mem_read;
    logic [REG_ADDR_W-1:0] idex_reg_rd;
    logic [REG_ADDR_W-1:0] ifid_reg_rs;
    logic [REG_ADDR_W-1:0] ifid_reg_rt;
    logic                  ifid_uses_rs;
    logic                  ifid_uses_rt;
    logic                  exmem_mem_access;
    logic                  mem_ready;
    logic                  branch_taken;
    logic                  ret_wb;
    logic                  hlt_wb;

    logic                  pc_en;
    logic                  ifid_en;
    logic                  ifid_flush;
    logic                  idex_en;
    logic                  idex_bubble;
    logic                  exmem_en;
    logic                  memwb_bubble;
    logic                  halted;
    logic                  mem_timeout;
    logic [1:0]            state;
`ifdef HAZARD_PERF_EN
    logic [15:0]           stall_cycles;
    logic [15:0]           flush_count;
`endif

    modport master (
        output idex_mem_read, idex_reg_rd, ifid_reg_rs, ifid_reg_rt,
               ifid_uses_rs, ifid_uses_rt, exmem_mem_access, mem_ready,
               branch_taken, ret_wb, hlt_wb,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               memwb_bubble, halted, mem_timeout, state
`ifdef HAZARD_PERF_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  idex_mem_read, idex_reg_rd, ifid_reg_rs, ifid_reg_rt,
               ifid_uses_rs, ifid_uses_rt, exmem_mem_access, mem_ready,
               branch_taken, ret_wb, hlt_wb,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               memwb_bubble, halted, mem_timeout, state
`ifdef HAZARD_PERF_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline; optional HAZARD_PERF_EN perf counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int REG_ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10,
        HALT     = 2'b11
    } state_t;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    state_t     state_q;
    state_t     state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;
    logic       timeout_q;

    reg_idx_t   rd;
    logic       load_use;
    logic       mem_stall;
    logic       redirect;
    logic       redirect_cyc;
    logic       wait_stall;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, halted;

    assign rd        = hz.idex_reg_rd;
    assign load_use  = hz.idex_mem_read && (rd != '0) &&
                       ((hz.ifid_uses_rs && (hz.ifid_reg_rs == rd)) ||
                        (hz.ifid_uses_rt && (hz.ifid_reg_rt == rd)));
    assign mem_stall = hz.exmem_mem_access && !hz.mem_ready;
    assign redirect  = hz.branch_taken || hz.ret_wb;

    // Counter only advances on genuine MEM_WAIT freeze cycles; anything else clears it.
    assign wait_stall = (state_q == MEM_WAIT) && !hz.hlt_wb && !hz.mem_ready;
    assign wait_inc   = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (wait_stall) begin
                wait_cnt <= wait_inc;
                if (wait_inc == CNT_MAX) timeout_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt    = state_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        redirect_cyc = 1'b0;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            state_nxt    = RUN;
        end else if (state_q == HALT || hz.hlt_wb) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            halted       = 1'b1;
            state_nxt    = HALT;
        end else if (state_q == MEM_WAIT) begin
            if (!hz.mem_ready) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end else begin
                state_nxt = RUN;
                if (redirect) begin
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    redirect_cyc = 1'b1;
                end
            end
        end else begin
            // RUN and LU_STALL; LU_STALL ignores load-use since EX now holds the bubble.
            if (mem_stall) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
                state_nxt    = MEM_WAIT;
            end else if (redirect) begin
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                redirect_cyc = 1'b1;
                state_nxt    = RUN;
            end else if (state_q == RUN && load_use) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_bubble  = 1'b1;
                state_nxt    = LU_STALL;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_en      = idex_en;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_en     = exmem_en;
    assign hz.memwb_bubble = memwb_bubble;
    assign hz.halted       = halted;
    assign hz.mem_timeout  = timeout_q;
    assign hz.state        = state_q;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && state_q != HALT && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (redirect_cyc && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
`else
    logic unused_redirect_cyc;
    assign unused_redirect_cyc = redirect_cyc;
`endif
endmodule
